// File: rtl/sc_sng_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sc_sng_bank
// Brief    : N-lane stochastic number generator bank. It turns binary
//            activations and weights into unipolar bitstreams using two
//            decorrelated maximal-length LFSRs and per-lane comparators.
//            The optional `stall` input is enabled by the macro SC_SNG_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sc_sng_bank #(
    parameter int          N      = 8,
    parameter int          W      = 8,
    parameter int unsigned SEED_X = 32'h5A,
    parameter int unsigned SEED_W = 32'hC3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
`ifdef SC_SNG_STALL_EN
    input  logic           stall,
`endif
    input  logic [N*W-1:0] x_in,
    input  logic [N*W-1:0] w_in,
    output logic [N-1:0]   din,
    output logic [N-1:0]   weight,
    output logic           valid,
    output logic           busy,
    output logic           done
);

    localparam int           L          = 2**W - 1;
    localparam int           c_cnt_w    = $clog2(L + 1);
    localparam logic [W-1:0] c_seed_x   = W'(SEED_X);
    localparam logic [W-1:0] c_seed_w   = W'(SEED_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(L - 1);

    if (W != 8 && W != 16) begin : g_bad_w
        $error("sc_sng_bank: W must be 8 or 16");
    end
    if (c_seed_x == '0) begin : g_bad_seed_x
        $error("sc_sng_bank: SEED_X must be nonzero");
    end
    if (c_seed_w == '0) begin : g_bad_seed_w
        $error("sc_sng_bank: SEED_W must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N*W-1:0]     r_x_op;
    logic [N*W-1:0]     r_w_op;
    logic [W-1:0]       r_lfsr_x;
    logic [W-1:0]       r_lfsr_w;
    logic [W-1:0]       w_rev_w;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-1:0]       r_din;
    logic [N-1:0]       r_weight;
    logic [N-1:0]       w_din_nxt;
    logic [N-1:0]       w_weight_nxt;
    logic               r_valid;
    logic               r_done;
    logic               w_fb_x;
    logic               w_fb_w;
    logic               w_stall;

`ifdef SC_SNG_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Fibonacci feedback, shift-left with the new bit entering bit 0
    if (W == 16) begin : g_taps16
        assign w_fb_x = r_lfsr_x[15] ^ r_lfsr_x[14] ^ r_lfsr_x[12] ^ r_lfsr_x[3];
        assign w_fb_w = r_lfsr_w[15] ^ r_lfsr_w[14] ^ r_lfsr_w[12] ^ r_lfsr_w[3];
    end else begin : g_taps8
        assign w_fb_x = r_lfsr_x[7] ^ r_lfsr_x[5] ^ r_lfsr_x[4] ^ r_lfsr_x[3];
        assign w_fb_w = r_lfsr_w[7] ^ r_lfsr_w[5] ^ r_lfsr_w[4] ^ r_lfsr_w[3];
    end

    for (genvar b = 0; b < W; b++) begin : g_rev
        assign w_rev_w[b] = r_lfsr_w[W-1-b];
    end

    // Per-lane rotation decorrelates lanes while keeping each lane a
    // permutation of 1..L, so the ones count stays exact.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int c_rot = i % W;
        logic [W-1:0] w_rot_x;
        logic [W-1:0] w_rot_w;
        if (c_rot == 0) begin : g_norot
            assign w_rot_x = r_lfsr_x;
            assign w_rot_w = w_rev_w;
        end else begin : g_rot
            assign w_rot_x = {r_lfsr_x[W-1-c_rot:0], r_lfsr_x[W-1:W-c_rot]};
            assign w_rot_w = {w_rev_w[W-1-c_rot:0], w_rev_w[W-1:W-c_rot]};
        end
        assign w_din_nxt[i]    = (w_rot_x <= r_x_op[i*W +: W]);
        assign w_weight_nxt[i] = (w_rot_w <= r_w_op[i*W +: W]);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (!w_stall && r_cnt == c_cnt_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x_op   <= '0;
            r_w_op   <= '0;
            r_lfsr_x <= c_seed_x;
            r_lfsr_w <= c_seed_w;
            r_cnt    <= '0;
            r_din    <= '0;
            r_weight <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x_op   <= x_in;
                        r_w_op   <= w_in;
                        r_lfsr_x <= c_seed_x;
                        r_lfsr_w <= c_seed_w;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_stall) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_din    <= w_din_nxt;
                        r_weight <= w_weight_nxt;
                        r_valid  <= 1'b1;
                        r_lfsr_x <= {r_lfsr_x[W-2:0], w_fb_x};
                        r_lfsr_w <= {r_lfsr_w[W-2:0], w_fb_w};
                        r_cnt    <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign din    = r_din;
    assign weight = r_weight;
    assign valid  = r_valid;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sc_sng_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sc_sng_bank
// Brief    : Self-checking bench for sc_sng_bank. Expected values come from the
//            stream rules: exact ones counts and L-cycle valid windows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_sng_bank;

    localparam int N = 8;
    localparam int W = 8;
    localparam int L = 2**W - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           stall;
    logic [N*W-1:0] x_in;
    logic [N*W-1:0] w_in;
    logic [N-1:0]   din;
    logic [N-1:0]   weight;
    logic           valid;
    logic           busy;
    logic           done;

    int n_cmp  = 0;
    int n_fail = 0;

    int s_valid_cnt, s_first_valid, s_last_valid, s_done_cycle, s_done_pulses;
    int s_ext_bad, s_busy_bad;
    int s_ones_x [N];
    int s_ones_w [N];

    sc_sng_bank #(.N(N), .W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
`ifdef SC_SNG_STALL_EN
        .stall  (stall),
`endif
        .x_in   (x_in),
        .w_in   (w_in),
        .din    (din),
        .weight (weight),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives start for the next rising edge (E0).
    task automatic begin_stream(input logic [N*W-1:0] x, input logic [N*W-1:0] w);
        @(negedge clk);
        x_in  = x;
        w_in  = w;
        start = 1'b1;
    endtask

    // Observes one stream cycle by cycle (k=1 is the negedge after E0) and
    // applies optional mid-stream stimulus for the following edge.
    task automatic collect(input int budget, input int pulse_a, input int pulse_b,
                           input int chg_at, input logic [N*W-1:0] chg_x,
                           input int stall_from, input int stall_len, input bit chk_ext);
        s_valid_cnt = 0; s_first_valid = -1; s_last_valid = -1;
        s_done_cycle = -1; s_done_pulses = 0; s_ext_bad = 0; s_busy_bad = 0;
        for (int i = 0; i < N; i++) begin
            s_ones_x[i] = 0;
            s_ones_w[i] = 0;
        end
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                s_valid_cnt++;
                if (s_first_valid < 0) s_first_valid = k;
                s_last_valid = k;
                for (int i = 0; i < N; i++) begin
                    if (din[i] === 1'b1) s_ones_x[i]++;
                    if (weight[i] === 1'b1) s_ones_w[i]++;
                end
                if (chk_ext && (din !== '0 || weight !== '1)) s_ext_bad++;
            end
            if (done === 1'b1) begin
                s_done_pulses++;
                if (s_done_cycle < 0) s_done_cycle = k;
            end
            if (busy !== (s_done_cycle < 0)) s_busy_bad++;
            if (s_done_cycle >= 0 && k == s_done_cycle + 1) break;
            start = (k == pulse_a || k == pulse_b);
            if (k == chg_at) x_in = chg_x;
            stall = (k >= stall_from && k < stall_from + stall_len);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset;
        logic [N*W-1:0] xa;
        reset = 1'b1; start = 1'b0; stall = 1'b0; x_in = '0; w_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (din !== '0)    begin n_fail++; $display("FAIL reset_din: got %h expected 0", din); end
        n_cmp++; if (weight !== '0) begin n_fail++; $display("FAIL reset_weight: got %h expected 0", weight); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end

        // Abort a stream at cycle 100 with an asynchronous reset.
        xa = '1;
        begin_stream(xa, xa);
        collect(100, -1, -1, -1, '0, -1, 0, 1'b0);
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL midrun_valid_before: got %b expected 1", valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || din !== '0 || weight !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b done=%b din=%h weight=%h expected all 0",
                     valid, busy, done, din, weight);
        end
        @(negedge clk);
        reset = 1'b0;
        collect(10, -1, -1, -1, '0, -1, 0, 1'b0);
        n_cmp++; if (s_done_pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", s_done_pulses); end

        xa = {N{8'd77}};
        begin_stream(xa, xa);
        collect(L + 10, -1, -1, -1, '0, -1, 0, 1'b0);
        n_cmp++; if (s_valid_cnt !== L) begin n_fail++; $display("FAIL post_reset_len: got %0d expected %0d", s_valid_cnt, L); end
        n_cmp++; if (s_done_cycle !== L + 2) begin n_fail++; $display("FAIL post_reset_done: got %0d expected %0d", s_done_cycle, L + 2); end
        n_cmp++; if (s_ones_x[3] !== 77) begin n_fail++; $display("FAIL post_reset_ones: got %0d expected 77", s_ones_x[3]); end
    endtask

    task automatic test_extremes;
        begin_stream('0, '1);
        collect(L + 10, -1, -1, -1, '0, -1, 0, 1'b1);
        n_cmp++; if (s_valid_cnt !== L) begin n_fail++; $display("FAIL ext_len: got %0d expected %0d", s_valid_cnt, L); end
        n_cmp++; if (s_ext_bad !== 0) begin n_fail++; $display("FAIL ext_bits: got %0d bad cycles expected 0", s_ext_bad); end
        n_cmp++; if (s_first_valid !== 2) begin n_fail++; $display("FAIL ext_first_valid: got %0d expected 2", s_first_valid); end
        n_cmp++; if (s_last_valid !== L + 1) begin n_fail++; $display("FAIL ext_last_valid: got %0d expected %0d", s_last_valid, L + 1); end
        n_cmp++; if (s_done_cycle !== L + 2) begin n_fail++; $display("FAIL ext_done_cycle: got %0d expected %0d", s_done_cycle, L + 2); end
        n_cmp++; if (s_done_pulses !== 1) begin n_fail++; $display("FAIL ext_done_width: got %0d expected 1", s_done_pulses); end
        n_cmp++; if (s_busy_bad !== 0) begin n_fail++; $display("FAIL ext_busy: got %0d bad cycles expected 0", s_busy_bad); end
    endtask

    task automatic test_exact_count;
        logic [N*W-1:0] x, w;
        for (int i = 0; i < N; i++) begin
            x[i*W +: W] = W'(32 * i);
            w[i*W +: W] = W'(255 - 30 * i);
        end
        begin_stream(x, w);
        collect(L + 10, -1, -1, -1, '0, -1, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (s_ones_x[i] !== 32 * i) begin
                n_fail++; $display("FAIL exact_din lane %0d: got %0d expected %0d", i, s_ones_x[i], 32 * i);
            end
            n_cmp++; if (s_ones_w[i] !== 255 - 30 * i) begin
                n_fail++; $display("FAIL exact_weight lane %0d: got %0d expected %0d", i, s_ones_w[i], 255 - 30 * i);
            end
        end
    endtask

    task automatic test_handshake;
        logic [N*W-1:0] x;
        for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom_range(0, L));
        begin_stream(x, x);
        collect(L + 10, 10, 200, -1, '0, -1, 0, 1'b0);
        n_cmp++; if (s_valid_cnt !== L) begin n_fail++; $display("FAIL hs_len: got %0d expected %0d", s_valid_cnt, L); end
        n_cmp++; if (s_done_cycle !== L + 2) begin n_fail++; $display("FAIL hs_done_cycle: got %0d expected %0d", s_done_cycle, L + 2); end
        n_cmp++; if (s_ones_x[N-1] !== int'(x[(N-1)*W +: W])) begin
            n_fail++; $display("FAIL hs_ones: got %0d expected %0d", s_ones_x[N-1], x[(N-1)*W +: W]);
        end
    endtask

    task automatic test_operand_latch;
        logic [N*W-1:0] x, w;
        for (int i = 0; i < N; i++) begin
            x[i*W +: W] = W'($urandom_range(1, L - 1));
            w[i*W +: W] = W'($urandom_range(0, L));
        end
        begin_stream(x, w);
        collect(L + 10, -1, -1, 50, ~x, -1, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (s_ones_x[i] !== int'(x[i*W +: W])) begin
                n_fail++; $display("FAIL latch lane %0d: got %0d expected %0d", i, s_ones_x[i], x[i*W +: W]);
            end
        end
    endtask

    task automatic test_random;
        logic [N*W-1:0] x, w;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                x[i*W +: W] = W'($urandom_range(0, L));
                w[i*W +: W] = W'($urandom_range(0, L));
            end
            if (t == 1) begin
                x[0 +: W] = '0;          x[(N-1)*W +: W] = '1;
                w[0 +: W] = '1;          w[(N-1)*W +: W] = '0;
            end
            begin_stream(x, w);
            collect(L + 10, -1, -1, -1, '0, -1, 0, 1'b0);
            n_cmp++; if (s_valid_cnt !== L) begin n_fail++; $display("FAIL rand_len t%0d: got %0d expected %0d", t, s_valid_cnt, L); end
            for (int i = 0; i < N; i++) begin
                n_cmp++; if (s_ones_x[i] !== int'(x[i*W +: W])) begin
                    n_fail++; $display("FAIL rand_din t%0d lane %0d: got %0d expected %0d", t, i, s_ones_x[i], x[i*W +: W]);
                end
                n_cmp++; if (s_ones_w[i] !== int'(w[i*W +: W])) begin
                    n_fail++; $display("FAIL rand_weight t%0d lane %0d: got %0d expected %0d", t, i, s_ones_w[i], w[i*W +: W]);
                end
            end
        end
    endtask

    // start held high: the restart edge is the one closing the done cycle
    // (EL+2), so the second stream's first bit lands L+2 cycles after the first.
    task automatic test_back_to_back;
        int rise [2];
        int dones [2];
        int n_rise, n_done;
        logic prev_v;
        logic busy_at_done;
        logic [N*W-1:0] x;
        for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom_range(0, L));
        n_rise = 0; n_done = 0; prev_v = 1'b0; busy_at_done = 1'b1;
        rise[0] = -1; rise[1] = -1; dones[0] = -1; dones[1] = -1;
        begin_stream(x, x);
        for (int k = 1; k <= 2 * L + 20; k++) begin
            @(negedge clk);
            if (valid === 1'b1 && prev_v === 1'b0 && n_rise < 2) begin
                rise[n_rise] = k;
                n_rise++;
                if (n_rise == 2) start = 1'b0;
            end
            if (done === 1'b1 && n_done < 2) begin
                dones[n_done] = k;
                if (n_done == 0) busy_at_done = busy;
                n_done++;
            end
            prev_v = valid;
            if (n_done == 2) break;
        end
        start = 1'b0;
        n_cmp++; if (rise[0] !== 2) begin n_fail++; $display("FAIL b2b_first_rise: got %0d expected 2", rise[0]); end
        n_cmp++; if (dones[0] !== L + 2) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", dones[0], L + 2); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done: got %b expected 0", busy_at_done); end
        n_cmp++; if (rise[1] !== dones[0] + 2) begin
            n_fail++; $display("FAIL b2b_restart: got %0d expected %0d", rise[1], dones[0] + 2);
        end
        n_cmp++; if (rise[1] - rise[0] !== L + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", rise[1] - rise[0], L + 2);
        end
        n_cmp++; if (dones[1] - dones[0] !== L + 2) begin
            n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", dones[1] - dones[0], L + 2);
        end
    endtask

`ifdef SC_SNG_STALL_EN
    task automatic test_stall;
        logic [N*W-1:0] x, w;
        x = {N{8'd100}};
        for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom_range(0, L));
        begin_stream(x, w);
        collect(L + 40, -1, -1, -1, '0, 60, 20, 1'b0);
        n_cmp++; if (s_valid_cnt !== L) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", s_valid_cnt, L); end
        n_cmp++; if (s_last_valid - s_first_valid + 1 !== L + 20) begin
            n_fail++; $display("FAIL stall_window: got %0d expected %0d", s_last_valid - s_first_valid + 1, L + 20);
        end
        n_cmp++; if (s_done_cycle !== L + 22) begin n_fail++; $display("FAIL stall_done: got %0d expected %0d", s_done_cycle, L + 22); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (s_ones_x[i] !== 100) begin
                n_fail++; $display("FAIL stall_din lane %0d: got %0d expected 100", i, s_ones_x[i]);
            end
            n_cmp++; if (s_ones_w[i] !== int'(w[i*W +: W])) begin
                n_fail++; $display("FAIL stall_weight lane %0d: got %0d expected %0d", i, s_ones_w[i], w[i*W +: W]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_extremes();
        test_exact_count();
        test_handshake();
        test_operand_latch();
        test_random();
        test_back_to_back();
`ifdef SC_SNG_STALL_EN
        test_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
